// File: rtl/score4_pkg.sv
// score4_pkg: cell encoding, scan directions, FSM states and default
// board geometry shared by the win scanner and its column checker.
package score4_pkg;

    localparam int DEF_COLS    = 7;
    localparam int DEF_ROWS    = 6;
    localparam int DEF_WIN_LEN = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10,
        BAD   = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_DN = 2'd2,
        DIR_UP = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/win_column_check.sv
// win_column_check: combinational test of every window anchored in one
// column; reports the first hit by direction (H>V>down>up), then lowest row.
module win_column_check
    import score4_pkg::*;
#(
    parameter  int COLS    = DEF_COLS,
    parameter  int ROWS    = DEF_ROWS,
    parameter  int WIN_LEN = DEF_WIN_LEN,
    localparam int CW      = $clog2(COLS),
    localparam int RW      = $clog2(ROWS)
) (
    input  logic [COLS-1:0][ROWS-1:0][1:0] i_panel,
    input  logic [CW-1:0]                  i_col,
    input  logic [1:0]                     i_code,
    output logic                           o_hit,
    output logic [1:0]                     o_dir,
    output logic [RW-1:0]                  o_row
);

    localparam int N = 4 * ROWS;

    logic [3:0]    w_win [COLS][ROWS];
    logic [3:0]    w_sel [ROWS];
    logic          w_found [N+1];
    dir_t          w_dir [N+1];
    logic [RW-1:0] w_row [N+1];

    // Windows leaving the board resolve to 0 at elaboration time.
    for (genvar c = 0; c < COLS; c++) begin : g_c
        for (genvar r = 0; r < ROWS; r++) begin : g_r
            logic [WIN_LEN-1:0] w_h, w_v, w_dn, w_up;
            for (genvar i = 0; i < WIN_LEN; i++) begin : g_i
                if (c + i < COLS) begin : g_h_in
                    assign w_h[i] = i_panel[c+i][r] == i_code;
                end else begin : g_h_out
                    assign w_h[i] = 1'b0;
                end
                if (r + i < ROWS) begin : g_v_in
                    assign w_v[i] = i_panel[c][r+i] == i_code;
                end else begin : g_v_out
                    assign w_v[i] = 1'b0;
                end
                if (c + i < COLS && r + i < ROWS) begin : g_dn_in
                    assign w_dn[i] = i_panel[c+i][r+i] == i_code;
                end else begin : g_dn_out
                    assign w_dn[i] = 1'b0;
                end
                if (c + i < COLS && r - i >= 0) begin : g_up_in
                    assign w_up[i] = i_panel[c+i][r-i] == i_code;
                end else begin : g_up_out
                    assign w_up[i] = 1'b0;
                end
            end
            assign w_win[c][r] = {&w_up, &w_dn, &w_v, &w_h};
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_sel
        assign w_sel[r] = w_win[i_col][r];
    end

    assign w_found[0] = 1'b0;
    assign w_dir[0]   = DIR_H;
    assign w_row[0]   = '0;

    // Priority chain: earlier (direction, row) slots win.
    for (genvar d = 0; d < 4; d++) begin : g_pd
        for (genvar r = 0; r < ROWS; r++) begin : g_pr
            localparam int K = d * ROWS + r;
            logic w_take;
            assign w_take       = w_sel[r][d] & ~w_found[K];
            assign w_found[K+1] = w_found[K] | w_sel[r][d];
            assign w_dir[K+1]   = w_take ? dir_t'(d) : w_dir[K];
            assign w_row[K+1]   = w_take ? RW'(r) : w_row[K];
        end
    end

    assign o_hit = w_found[N];
    assign o_dir = w_dir[N];
    assign o_row = w_row[N];

endmodule

// File: rtl/win_scanner.sv
// win_scanner: column-serial four-in-a-row detector with early exit.
// Define WIN_SCANNER_LOCATE_EN to add win_col/win_row/win_dir outputs.
module win_scanner
    import score4_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [COLS-1:0][ROWS-1:0][1:0] panel,
    input  logic                           turn,
    output logic                           busy,
    output logic                           done,
    output logic                           exists,
    output logic                           winner,
    output logic                           draw
`ifdef WIN_SCANNER_LOCATE_EN
    ,
    output logic [$clog2(COLS)-1:0]        win_col,
    output logic [$clog2(ROWS)-1:0]        win_row,
    output logic [1:0]                     win_dir
`endif
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST = CW'(COLS - 1);

    if (WIN_LEN < 2 || WIN_LEN > COLS || WIN_LEN > ROWS) begin : g_bad_len
        $error("win_scanner: WIN_LEN must lie in 2..min(COLS,ROWS)");
    end

    state_t                         r_state, w_next;
    logic [CW-1:0]                  r_col;
    logic [COLS-1:0][ROWS-1:0][1:0] r_panel;
    logic                           r_turn;
    logic                           r_exists, r_winner, r_draw;

    logic [1:0]           w_code;
    logic                 w_hit;
    logic [1:0]           w_dir;
    logic [RW-1:0]        w_row;
    logic [COLS*ROWS-1:0] w_open;
    logic                 w_full;

    // Only the player who just moved can have completed a run.
    assign w_code = r_turn ? P0 : P1;

    for (genvar c = 0; c < COLS; c++) begin : g_oc
        for (genvar r = 0; r < ROWS; r++) begin : g_or
            assign w_open[c*ROWS+r] = (r_panel[c][r] == EMPTY) ||
                                      (r_panel[c][r] == BAD);
        end
    end
    assign w_full = ~|w_open;

    win_column_check #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .WIN_LEN (WIN_LEN)
    ) u_check (
        .i_panel (r_panel),
        .i_col   (r_col),
        .i_code  (w_code),
        .o_hit   (w_hit),
        .o_dir   (w_dir),
        .o_row   (w_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_SCAN;
            S_SCAN:   if (w_hit || r_col == LAST) w_next = S_REPORT;
            S_REPORT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Results are registered on the way into REPORT so they line up with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= '0;
            r_panel  <= '0;
            r_turn   <= 1'b0;
            r_exists <= 1'b0;
            r_winner <= 1'b0;
            r_draw   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_panel  <= panel;
                        r_turn   <= turn;
                        r_col    <= '0;
                        r_exists <= 1'b0;
                        r_winner <= 1'b0;
                        r_draw   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_exists <= 1'b1;
                        r_winner <= ~r_turn;
                    end else if (r_col == LAST) begin
                        r_draw <= w_full;
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_state != S_IDLE;
    assign done   = r_state == S_REPORT;
    assign exists = r_exists;
    assign winner = r_winner;
    assign draw   = r_draw;

`ifdef WIN_SCANNER_LOCATE_EN
    logic [CW-1:0] r_win_col;
    logic [RW-1:0] r_win_row;
    logic [1:0]    r_win_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_col <= '0;
            r_win_row <= '0;
            r_win_dir <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_win_col <= '0;
            r_win_row <= '0;
            r_win_dir <= '0;
        end else if (r_state == S_SCAN && w_hit) begin
            r_win_col <= r_col;
            r_win_row <= w_row;
            r_win_dir <= w_dir;
        end
    end

    assign win_col = r_win_col;
    assign win_row = r_win_row;
    assign win_dir = r_win_dir;
`else
    logic w_unused_loc;
    assign w_unused_loc = ^{w_dir, w_row};
`endif

endmodule

// File: tb/tb_win_scanner.sv
// tb_win_scanner: table-driven directed vectors for win_scanner plus
// hand-written sequences for ignored restarts and mid-scan reset.
module tb_win_scanner;

    typedef logic [6:0][5:0][1:0] panel_t;

    typedef struct {
        panel_t panel;
        logic   turn;
        int     lat;
        int     ex;
        int     win;
        int     drw;
        int     col;
        int     row;
        int     dir;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst, start, turn;
    panel_t panel;
    logic   busy, done, exists, winner, draw;
`ifdef WIN_SCANNER_LOCATE_EN
    logic [2:0] win_col, win_row;
    logic [1:0] win_dir;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    win_scanner dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .panel   (panel),
        .turn    (turn),
        .busy    (busy),
        .done    (done),
        .exists  (exists),
        .winner  (winner),
        .draw    (draw)
`ifdef WIN_SCANNER_LOCATE_EN
        ,
        .win_col (win_col),
        .win_row (win_row),
        .win_dir (win_dir)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic panel_t put4(panel_t p, int c, int r, int dc,
                                    int dr, logic [1:0] v);
        for (int i = 0; i < 4; i++) p[c+i*dc][r+i*dr] = v;
        return p;
    endfunction

    // Pairs of columns alternate, rows alternate: no run of 4 anywhere.
    function automatic panel_t full_board();
        panel_t p;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                p[c][r] = (((r + c / 2) % 2) == 1) ? 2'b10 : 2'b01;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},   32'(busy),   0);
        chk({tag, ".done"},   32'(done),   0);
        chk({tag, ".exists"}, 32'(exists), 0);
        chk({tag, ".winner"}, 32'(winner), 0);
        chk({tag, ".draw"},   32'(draw),   0);
`ifdef WIN_SCANNER_LOCATE_EN
        chk({tag, ".col"}, 32'(win_col), 0);
        chk({tag, ".row"}, 32'(win_row), 0);
        chk({tag, ".dir"}, 32'(win_dir), 0);
`endif
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int lat;
        panel = v.panel;
        turn  = v.turn;
        start = 1'b1;
        step();
        start = 1'b0;
        panel = '0;
        turn  = ~v.turn;
        chk($sformatf("v%0d.busy", k), 32'(busy), 1);
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        chk($sformatf("v%0d.lat", k),    lat,          v.lat);
        chk($sformatf("v%0d.exists", k), 32'(exists), v.ex);
        chk($sformatf("v%0d.winner", k), 32'(winner), v.win);
        chk($sformatf("v%0d.draw", k),   32'(draw),   v.drw);
`ifdef WIN_SCANNER_LOCATE_EN
        chk($sformatf("v%0d.col", k), 32'(win_col), v.col);
        chk($sformatf("v%0d.row", k), 32'(win_row), v.row);
        chk($sformatf("v%0d.dir", k), 32'(win_dir), v.dir);
`endif
        step();
        chk($sformatf("v%0d.done_off", k), 32'(done), 0);
        chk($sformatf("v%0d.busy_off", k), 32'(busy), 0);
        step();
        step();
        chk($sformatf("v%0d.hold_ex", k), 32'(exists), v.ex);
        chk($sformatf("v%0d.hold_dr", k), 32'(draw),   v.drw);
    endtask

    initial begin
        panel_t e, f, g;
        int     cnt;
        e = '0;
        f = full_board();
        g = f;
        g[6][5] = 2'b11;

        tbl.push_back(vec_t'{put4(e, 3, 0, 1, 0, 2'b10), 1'b0, 5, 1, 1, 0, 3, 0, 0});
        tbl.push_back(vec_t'{e, 1'b0, 8, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{put4(e, 0, 2, 0, 1, 2'b01), 1'b1, 2, 1, 0, 0, 0, 2, 1});
        tbl.push_back(vec_t'{f, 1'b0, 8, 0, 0, 1, 0, 0, 0});
        tbl.push_back(vec_t'{g, 1'b0, 8, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{put4(e, 2, 5, 1, -1, 2'b01), 1'b0, 8, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{put4(e, 2, 5, 1, -1, 2'b01), 1'b1, 4, 1, 0, 0, 2, 5, 3});
        tbl.push_back(vec_t'{put4(e, 0, 0, 0, 1, 2'b11), 1'b0, 8, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{put4(put4(e, 0, 0, 1, 0, 2'b10), 0, 0, 0, 1, 2'b10),
                             1'b0, 2, 1, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{put4(put4(e, 0, 4, 1, 0, 2'b01), 0, 1, 1, 0, 2'b01),
                             1'b1, 2, 1, 0, 0, 0, 1, 0});
        tbl.push_back(vec_t'{put4(e, 1, 0, 1, 1, 2'b10), 1'b0, 3, 1, 1, 0, 1, 0, 2});
        tbl.push_back(vec_t'{put4(e, 6, 2, 0, 1, 2'b01), 1'b1, 8, 1, 0, 0, 6, 2, 1});
        tbl.push_back(vec_t'{f, 1'b1, 8, 0, 0, 1, 0, 0, 0});

        rst   = 1'b1;
        start = 1'b0;
        turn  = 1'b0;
        panel = '0;
        step();
        step();
        chk_quiet("reset");
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) run_vec(k, tbl[k]);

        // Restart request during SCAN, with a changed panel, is ignored.
        panel = tbl[2].panel;
        turn  = 1'b1;
        start = 1'b1;
        step();
        chk("busy_t1", 32'(busy), 1);
        panel = '0;
        turn  = 1'b0;
        step();
        chk("ign.done",   32'(done),   1);
        chk("ign.exists", 32'(exists), 1);
        chk("ign.winner", 32'(winner), 0);
        start = 1'b0;
        step();
        chk("ign.done_off", 32'(done), 0);
        chk("ign.busy_off", 32'(busy), 0);
        cnt = 0;
        repeat (10) begin
            step();
            if (done) cnt++;
        end
        chk("ign.extra_done", cnt, 0);
        chk("ign.hold", 32'(exists), 1);

        // Reset in cycle t+3 abandons the scan; next start runs normally.
        panel = '0;
        turn  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid.busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        step();
        chk("midrst.done", 32'(done), 0);
        chk("midrst.busy", 32'(busy), 0);
        rst = 1'b0;
        run_vec(100, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
